// File: rtl/scfifo_rr_drain_sched.sv
// Round-robin drain scheduler: pops bounded bursts from a bank of show-ahead
// FIFOs into one registered valid/ready stream tagged with the source index.
module scfifo_rr_drain_sched #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 20,
  parameter int MAX_BURST = 8,
  parameter int SEL_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                       clock,
  input  logic                       aclr_n,
  input  logic                       sclr,
  input  logic [NUM_REQ-1:0]         fifo_empty,
  input  logic [NUM_REQ*WIDTH-1:0]   fifo_q,
  output logic [NUM_REQ-1:0]         fifo_rdreq,
  output logic [WIDTH-1:0]           out_data,
  output logic [SEL_WIDTH-1:0]       out_src,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                          r_state, w_nstate;
  logic [SEL_WIDTH-1:0]            r_gnt, r_ptr, w_found, w_idx;
  logic [CNT_W-1:0]                r_cnt;
  logic [WIDTH-1:0]                r_data;
  logic [SEL_WIDTH-1:0]            r_src;
  logic                            r_valid;
  logic                            w_hit, w_pop, w_last, w_exit;
  logic [NUM_REQ-1:0][WIDTH-1:0]   w_q;

  assign w_q       = fifo_q;
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_valid = r_valid;

  // Scan from farthest to nearest so the source closest after r_ptr wins.
  always_comb begin
    w_hit   = 1'b0;
    w_found = '0;
    w_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = SEL_WIDTH'((int'(r_ptr) + k) % NUM_REQ);
      if (!fifo_empty[w_idx]) begin
        w_hit   = 1'b1;
        w_found = w_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n)   r_state <= S_IDLE;
    else if (sclr) r_state <= S_IDLE;
    else           r_state <= w_nstate;
  end

  // Pop is gated by sclr so a clear never silently consumes a source word.
  always_comb begin
    w_nstate = r_state;
    w_pop    = 1'b0;
    w_last   = 1'b0;
    w_exit   = 1'b0;
    case (r_state)
      S_IDLE: if (w_hit) w_nstate = S_BURST;
      S_BURST: begin
        w_pop  = ~sclr & ~fifo_empty[r_gnt] & (~r_valid | out_ready);
        w_last = (r_cnt == CNT_W'(MAX_BURST - 1));
        w_exit = fifo_empty[r_gnt] | (w_pop & w_last);
        if (w_exit) w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_rdreq = '0;
    if (w_pop) fifo_rdreq[r_gnt] = 1'b1;
    busy = (r_state == S_BURST);
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_gnt   <= '0;
      r_ptr   <= SEL_WIDTH'(NUM_REQ - 1);
      r_cnt   <= '0;
      r_data  <= '0;
      r_src   <= '0;
      r_valid <= 1'b0;
    end else if (sclr) begin
      r_gnt   <= '0;
      r_ptr   <= SEL_WIDTH'(NUM_REQ - 1);
      r_cnt   <= '0;
      r_data  <= '0;
      r_src   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_hit) begin
        r_gnt <= w_found;
        r_cnt <= '0;
      end
      if (w_exit) r_ptr <= r_gnt;
      if (w_pop) begin
        r_data  <= w_q[r_gnt];
        r_src   <= r_gnt;
        r_valid <= 1'b1;
        r_cnt   <= r_cnt + 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule
